// File: rtl/alu_seq_if.sv
// alu_seq_if: operand, handshake and result bundle between operand fetch, the ALU and writeback.
interface alu_seq_if #(parameter int DATA_WIDTH = 8);
  logic                          in_valid;
  logic                          in_ready;
  logic [4:0]                    func_in;
  logic [DATA_WIDTH-1:0]         w_in;
  logic [DATA_WIDTH-1:0]         f_in;
  logic [DATA_WIDTH-1:0]         l_in;
  logic [$clog2(DATA_WIDTH)-1:0] bit_sel;
  logic                          status_wr_en;
  logic [2:0]                    status_wr_data;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         result_out;
  logic [DATA_WIDTH-1:0]         result_hi_out;
  logic [2:0]                    status_out;
  logic                          busy;
  modport master (
    output in_valid, func_in, w_in, f_in, l_in, bit_sel, status_wr_en, status_wr_data,
    input  in_ready, out_valid, result_out, result_hi_out, status_out, busy
  );
  modport slave (
    input  in_valid, func_in, w_in, f_in, l_in, bit_sel, status_wr_en, status_wr_data,
    output in_ready, out_valid, result_out, result_hi_out, status_out, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered PIC16C5x-style ALU owning STATUS {Z,DC,C}, with an optional
// iterative shift-add multiplier behind the valid/ready handshake.
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter bit ENABLE_MUL = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int H  = DW / 2;
  localparam int CW = $clog2(DW) + 1;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND = 5'd2, COM = 5'd3, DEC = 5'd4,
                         INC = 5'd5, IOR = 5'd6, RLF = 5'd7, RRF = 5'd8, SWAP = 5'd9,
                         XOR = 5'd10, BCF = 5'd11, BSF = 5'd12, MOVF = 5'd13, CLR = 5'd14,
                         MUL = 5'd15, ANDLW = 5'd16, IORLW = 5'd17, XORLW = 5'd18;
  logic              r_busy, r_out_valid;
  logic [DW-1:0]     r_result, r_result_hi, r_mcand;
  logic [2:0]        r_status;
  logic [2*DW-1:0]   r_p;
  logic [CW-1:0]     r_cnt;
  logic              w_accept, w_is_mul, w_mul_done, w_zu, w_dc, w_c;
  logic [DW-1:0]     w_res, w_f, w_w, w_mask;
  logic [DW:0]       w_sum, w_diff, w_step;
  logic [H:0]        w_hsum;
  logic [2*DW-1:0]   w_prod;
  logic [2:0]        w_flags;
  assign w_accept   = bus.in_valid && !r_busy;
  assign w_is_mul   = ENABLE_MUL && bus.func_in == MUL;
  assign w_mul_done = r_busy && r_cnt == CW'(1);
  // One shift-add step: add multiplicand into the high half when the current multiplier bit is set.
  assign w_step = {1'b0, r_p[2*DW-1:DW]} + (r_p[0] ? {1'b0, r_mcand} : '0);
  assign w_prod = {w_step, r_p[DW-1:1]};
  assign bus.in_ready      = !r_busy;
  assign bus.busy          = r_busy;
  assign bus.out_valid     = r_out_valid;
  assign bus.result_out    = r_result;
  assign bus.result_hi_out = r_result_hi;
  assign bus.status_out    = r_status;
  always_comb begin
    w_f    = bus.f_in;
    w_w    = bus.w_in;
    w_sum  = {1'b0, w_f} + {1'b0, w_w};
    w_diff = {1'b0, w_f} - {1'b0, w_w};
    w_hsum = {1'b0, w_f[H-1:0]} + {1'b0, w_w[H-1:0]};
    w_mask = (32'(bus.bit_sel) < DW) ? (DW'(1) << bus.bit_sel) : '0;
    w_res  = '0;
    w_zu   = 1'b1;
    w_dc   = r_status[1];
    w_c    = r_status[0];
    case (bus.func_in)
      ADD:   begin w_res = w_sum[DW-1:0]; w_dc = w_hsum[H]; w_c = w_sum[DW]; end
      SUB:   begin w_res = w_diff[DW-1:0]; w_dc = w_f[H-1:0] >= w_w[H-1:0]; w_c = !w_diff[DW]; end
      AND:   w_res = w_f & w_w;
      COM:   w_res = ~w_f;
      DEC:   w_res = w_f - DW'(1);
      INC:   w_res = w_f + DW'(1);
      IOR:   w_res = w_f | w_w;
      RLF:   begin w_res = {w_f[DW-2:0], r_status[0]}; w_c = w_f[DW-1]; w_zu = 1'b0; end
      RRF:   begin w_res = {r_status[0], w_f[DW-1:1]}; w_c = w_f[0]; w_zu = 1'b0; end
      SWAP:  begin w_res = {w_f[H-1:0], w_f[DW-1:H]}; w_zu = 1'b0; end
      XOR:   w_res = w_f ^ w_w;
      BCF:   begin w_res = w_f & ~w_mask; w_zu = 1'b0; end
      BSF:   begin w_res = w_f | w_mask; w_zu = 1'b0; end
      MOVF:  w_res = w_f;
      CLR:   w_res = '0;
      ANDLW: w_res = w_w & bus.l_in;
      IORLW: w_res = w_w | bus.l_in;
      XORLW: w_res = w_w ^ bus.l_in;
      default: w_zu = 1'b0;
    endcase
    w_flags = {w_zu ? (w_res == '0) : r_status[2], w_dc, w_c};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_status    <= '0;
      r_mcand     <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && w_is_mul) begin
        r_busy  <= 1'b1;
        r_cnt   <= CW'(DW);
        r_p     <= {{DW{1'b0}}, bus.f_in};
        r_mcand <= bus.w_in;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_result_hi <= '0;
      end
      if (r_busy) begin
        r_p   <= w_prod;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_mul_done) begin
        r_busy      <= 1'b0;
        r_out_valid <= 1'b1;
        r_result    <= w_prod[DW-1:0];
        r_result_hi <= w_prod[2*DW-1:DW];
      end
      // A direct STATUS write overrides any flag update completing on the same edge.
      r_status <= bus.status_wr_en ? bus.status_wr_data :
                  w_mul_done ? {w_prod == '0, r_status[1:0]} :
                  (w_accept && !w_is_mul) ? w_flags : r_status;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq with hand-computed expectations.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  alu_seq_if #(.DATA_WIDTH(8)) bus ();
  alu_seq #(.DATA_WIDTH(8), .ENABLE_MUL(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [4:0] fn, input logic [7:0] w, input logic [7:0] f,
                    input logic [7:0] l, input logic [2:0] b);
    bus.in_valid = 1'b1;
    bus.func_in  = fn;
    bus.w_in     = w;
    bus.f_in     = f;
    bus.l_in     = l;
    bus.bit_sel  = b;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic res(input string tag, input logic [7:0] r, input logic [2:0] s);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".res"}, 32'(bus.result_out), 32'(r));
    chk({tag, ".status"}, 32'(bus.status_out), 32'(s));
  endtask
  initial begin
    logic saw_valid;
    bus.in_valid = 1'b0;
    bus.func_in = 5'd0;
    bus.w_in = 8'h00;
    bus.f_in = 8'h00;
    bus.l_in = 8'h00;
    bus.bit_sel = 3'd0;
    bus.status_wr_en = 1'b0;
    bus.status_wr_data = 3'b000;
    step();
    step();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.res", 32'(bus.result_out), 32'd0);
    chk("rst.hi", 32'(bus.result_hi_out), 32'd0);
    chk("rst.status", 32'(bus.status_out), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();
    op(5'd0, 8'h0F, 8'h01, 8'h00, 3'd0); res("add0f01", 8'h10, 3'b010);
    chk("add.hi", 32'(bus.result_hi_out), 32'd0);
    step();
    chk("idle.valid", 32'(bus.out_valid), 32'd0);
    chk("idle.hold", 32'(bus.result_out), 32'h10);
    op(5'd1, 8'h05, 8'h05, 8'h00, 3'd0); res("sub55", 8'h00, 3'b111);
    op(5'd1, 8'h06, 8'h05, 8'h00, 3'd0); res("sub56", 8'hFF, 3'b000);
    bus.status_wr_en = 1'b1; bus.status_wr_data = 3'b110;
    step();
    bus.status_wr_en = 1'b0;
    chk("wr.status", 32'(bus.status_out), 32'b110);
    chk("wr.novalid", 32'(bus.out_valid), 32'd0);
    op(5'd7, 8'h00, 8'h80, 8'h00, 3'd0); res("rlf80", 8'h00, 3'b111);
    op(5'd7, 8'h00, 8'h00, 8'h00, 3'd0); res("rlf00", 8'h01, 3'b110);
    op(5'd8, 8'h00, 8'h01, 8'h00, 3'd0); res("rrf01", 8'h00, 3'b111);
    op(5'd9, 8'h00, 8'hA5, 8'h00, 3'd0); res("swap", 8'h5A, 3'b111);
    op(5'd4, 8'h00, 8'h00, 8'h00, 3'd0); res("dec00", 8'hFF, 3'b011);
    op(5'd5, 8'h00, 8'hFF, 8'h00, 3'd0); res("incff", 8'h00, 3'b111);
    op(5'd12, 8'h00, 8'h00, 8'h00, 3'd7); res("bsf7", 8'h80, 3'b111);
    op(5'd11, 8'h00, 8'hFF, 8'h00, 3'd0); res("bcf0", 8'hFE, 3'b111);
    op(5'd3, 8'h00, 8'h0F, 8'h00, 3'd0); res("com", 8'hF0, 3'b011);
    op(5'd18, 8'h3C, 8'h00, 8'h3C, 3'd0); res("xorlw", 8'h00, 3'b111);
    op(5'd17, 8'h10, 8'h00, 8'h01, 3'd0); res("iorlw", 8'h11, 3'b011);
    op(5'd2, 8'hF0, 8'h0F, 8'h00, 3'd0); res("and", 8'h00, 3'b111);
    op(5'd16, 8'hF0, 8'h00, 8'h3C, 3'd0); res("andlw", 8'h30, 3'b011);
    op(5'd19, 8'hF0, 8'h55, 8'h3C, 3'd0); res("undef", 8'h00, 3'b011);
    op(5'd13, 8'h00, 8'h00, 8'h00, 3'd0); res("movf", 8'h00, 3'b111);
    op(5'd10, 8'h0F, 8'hFF, 8'h00, 3'd0); res("xor", 8'hF0, 3'b011);
    op(5'd14, 8'h00, 8'h55, 8'h00, 3'd0); res("clr", 8'h00, 3'b111);
    op(5'd6, 8'h00, 8'h00, 8'h00, 3'd0); res("ior", 8'h00, 3'b111);
    op(5'd0, 8'hFF, 8'h01, 8'h00, 3'd0); res("addff01", 8'h00, 3'b111);
    bus.status_wr_en = 1'b1; bus.status_wr_data = 3'b000;
    op(5'd7, 8'h00, 8'h00, 8'h00, 3'd0); res("rlf.coll", 8'h01, 3'b000);
    bus.status_wr_data = 3'b010;
    op(5'd0, 8'hFF, 8'h01, 8'h00, 3'd0); res("add.coll", 8'h00, 3'b010);
    bus.status_wr_data = 3'b011;
    step();
    bus.status_wr_en = 1'b0;
    op(5'd15, 8'hFF, 8'hFF, 8'h00, 3'd0);
    chk("mul.busy0", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b1; bus.func_in = 5'd0; bus.w_in = 8'h01; bus.f_in = 8'h01;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("mul.ready%0d", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("mul.nov%0d", i), 32'(bus.out_valid), 32'd0);
    end
    step();
    bus.in_valid = 1'b0;
    res("mulffff", 8'h01, 3'b011);
    chk("mul.hi", 32'(bus.result_hi_out), 32'hFE);
    chk("mul.busy", 32'(bus.busy), 32'd0);
    step();
    chk("mul.pulse", 32'(bus.out_valid), 32'd0);
    chk("mul.holdhi", 32'(bus.result_hi_out), 32'hFE);
    op(5'd0, 8'h01, 8'h01, 8'h00, 3'd0); res("add.aftermul", 8'h02, 3'b000);
    chk("add.hi0", 32'(bus.result_hi_out), 32'd0);
    op(5'd15, 8'h00, 8'h37, 8'h00, 3'd0);
    repeat (8) step();
    res("mul0", 8'h00, 3'b100);
    op(5'd15, 8'hFF, 8'hFF, 8'h00, 3'd0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.out_valid), 32'd0);
    chk("arst.res", 32'(bus.result_out), 32'd0);
    chk("arst.hi", 32'(bus.result_hi_out), 32'd0);
    chk("arst.status", 32'(bus.status_out), 32'd0);
    chk("arst.busy", 32'(bus.busy), 32'd0);
    step();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      step();
      saw_valid = saw_valid | bus.out_valid;
    end
    chk("arst.noreport", 32'(saw_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
